// File: rtl/mac_seq_ctrl_pkg.sv
// Shared MAC widths, mode encodings, sequencer state encoding and the MAC config payload.
package mac_seq_ctrl_pkg;

  localparam int unsigned MAC_MIN_WIDTH  = 8;
  localparam int unsigned MAC_ACC_WIDTH  = 32;
  localparam int unsigned MAC_CONF_WIDTH = 3;
  localparam int unsigned MAC_LEN_WIDTH  = 8;

  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;

  typedef enum logic [2:0] {
    MAC_SEQ_IDLE  = 3'd0,
    MAC_SEQ_LOAD  = 3'd1,
    MAC_SEQ_RUN   = 3'd2,
    MAC_SEQ_DRAIN = 3'd3,
    MAC_SEQ_DONE  = 3'd4
  } mac_seq_state_e;

  // Layout matches the MAC cfg port: {init, accumulate select, mode}.
  typedef struct packed {
    logic [MAC_ACC_WIDTH-1:0] init;
    logic                     acc;
    logic [1:0]               mode;
  } mac_cfg_t;

endpackage

// File: rtl/mac_seq_cnt.sv
// Beat counter: clears on job accept, counts accepted beats, flags the final beat.
module mac_seq_cnt
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = MAC_LEN_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] len,
  output logic [W-1:0] cnt,
  output logic         last_c
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  // Only meaningful for len >= 1; zero-length jobs never enter RUN.
  assign last_c = (cnt == (len - W'(1)));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for an external mac_block: command in, len operand beats streamed, one result out.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [1:0]                              cmd_mode,
  input  logic                                    cmd_acc,
  input  logic [MAC_ACC_WIDTH-1:0]                cmd_init,
  input  logic [MAC_LEN_WIDTH-1:0]                cmd_len,
  input  logic                                    abort,
  input  logic                                    op_valid,
  output logic                                    op_ready,
  input  logic [MAC_MIN_WIDTH-1:0]                op_a,
  input  logic [MAC_MIN_WIDTH-1:0]                op_b,
  input  logic [MAC_MIN_WIDTH-1:0]                op_dual,
  input  logic [MAC_MIN_WIDTH-1:0]                op_q1,
  input  logic [MAC_MIN_WIDTH-1:0]                op_q2,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [MAC_ACC_WIDTH-1:0]                res_data,
  output logic [MAC_LEN_WIDTH-1:0]                res_beats,
  output logic                                    busy,
  output logic                                    mac_clr,
  output logic                                    mac_en,
  output logic [MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic [MAC_MIN_WIDTH-1:0]                mac_a,
  output logic [MAC_MIN_WIDTH-1:0]                mac_b,
  output logic [MAC_MIN_WIDTH-1:0]                mac_dual,
  output logic [MAC_MIN_WIDTH-1:0]                mac_q1,
  output logic [MAC_MIN_WIDTH-1:0]                mac_q2,
  input  logic [MAC_ACC_WIDTH-1:0]                mac_c
);

  mac_seq_state_e             state;
  mac_cfg_t                   job_cfg;
  logic [MAC_LEN_WIDTH-1:0]   job_len;
  logic [MAC_LEN_WIDTH-1:0]   beat_cnt;
  logic                       zero_len;
  logic                       cnt_last_c;
  logic                       cmd_fire;
  logic                       beat_fire;
  logic                       abort_hit;

  // Operands pass straight through; the MAC only samples them when mac_en is high.
  assign mac_a    = op_a;
  assign mac_b    = op_b;
  assign mac_dual = op_dual;
  assign mac_q1   = op_q1;
  assign mac_q2   = op_q2;

  assign mac_en    = op_valid & op_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign abort_hit = abort & ((state == MAC_SEQ_LOAD) || (state == MAC_SEQ_RUN) ||
                              (state == MAC_SEQ_DRAIN));
  assign beat_fire = mac_en & ~abort;

  mac_seq_cnt #(
    .W (MAC_LEN_WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cmd_fire),
    .inc    (beat_fire),
    .len    (job_len),
    .cnt    (beat_cnt),
    .last_c (cnt_last_c)
  );

  // State and all handshake/control outputs are registered together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= MAC_SEQ_IDLE;
      cmd_ready <= 1'b0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_cfg   <= '0;
      res_data  <= '0;
      res_beats <= '0;
      job_cfg   <= '0;
      job_len   <= '0;
      zero_len  <= 1'b0;
    end else if (abort_hit) begin
      state     <= MAC_SEQ_IDLE;
      cmd_ready <= 1'b1;
      op_ready  <= 1'b0;
      busy      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_cfg   <= '0;
      zero_len  <= 1'b0;
    end else begin
      unique case (state)
        MAC_SEQ_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            state     <= MAC_SEQ_LOAD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            mac_clr   <= 1'b1;
            job_cfg   <= {cmd_init, cmd_acc, cmd_mode};
            mac_cfg   <= {cmd_init, cmd_acc, cmd_mode};
            job_len   <= cmd_len;
            zero_len  <= 1'b0;
          end
        end
        MAC_SEQ_LOAD: begin
          mac_clr <= 1'b0;
          if (job_len == '0) begin
            state    <= MAC_SEQ_DRAIN;
            zero_len <= 1'b1;
          end else begin
            state    <= MAC_SEQ_RUN;
            op_ready <= 1'b1;
          end
        end
        MAC_SEQ_RUN: begin
          if (beat_fire && cnt_last_c) begin
            state    <= MAC_SEQ_DRAIN;
            op_ready <= 1'b0;
          end
        end
        MAC_SEQ_DRAIN: begin
          // mac_c already reflects the final beat thanks to the MAC output register.
          state     <= MAC_SEQ_DONE;
          res_data  <= zero_len ? job_cfg.init : mac_c;
          res_beats <= beat_cnt;
          res_valid <= 1'b1;
          mac_cfg   <= '0;
        end
        MAC_SEQ_DONE: begin
          if (res_ready) begin
            state     <= MAC_SEQ_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= MAC_SEQ_IDLE;
          cmd_ready <= 1'b0;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          mac_clr   <= 1'b0;
          mac_cfg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC model closing the loop on mac_c.
module tb_mac_seq_ctrl;
  import mac_seq_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic        cmd_acc;
  logic [31:0] cmd_init;
  logic [7:0]  cmd_len;
  logic        abort;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a, op_b, op_dual, op_q1, op_q2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_beats;
  logic        busy;
  logic        mac_clr;
  logic        mac_en;
  logic [34:0] mac_cfg;
  logic [7:0]  mac_a, mac_b, mac_dual, mac_q1, mac_q2;
  logic [31:0] mac_c;
  logic [31:0] mac_acc;

  int total;
  int bad;

  typedef struct packed {
    logic [1:0]  mode;
    logic        acc;
    logic [31:0] init;
    logic [7:0]  len;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic [7:0]  d;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_acc(cmd_acc), .cmd_init(cmd_init), .cmd_len(cmd_len),
    .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dual(op_dual), .op_q1(op_q1), .op_q2(op_q2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_beats(res_beats), .busy(busy),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_cfg(mac_cfg),
    .mac_a(mac_a), .mac_b(mac_b), .mac_dual(mac_dual), .mac_q1(mac_q1),
    .mac_q2(mac_q2), .mac_c(mac_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] prod(input logic [1:0] m, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] d,
                                       input logic [7:0] q1, input logic [7:0] q2);
    logic [31:0] pa, pd, p1, p2;
    pa = 32'(a) * 32'(b);
    pd = 32'(d) * 32'(b);
    p1 = 32'(q1) * 32'(b);
    p2 = 32'(q2) * 32'(b);
    case (m)
      2'b00:   return pa;
      2'b01:   return pa + (pd << 8);
      2'b10:   return pa + (pd << 8) + (p1 << 16) + (p2 << 24);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural mac_block: registered accumulator, clear loads init from cfg.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_acc <= '0;
    end else if (mac_clr) begin
      mac_acc <= mac_cfg[34:3];
    end else if (mac_en) begin
      if (mac_cfg[1:0] == 2'b11)
        mac_acc <= '0;
      else
        mac_acc <= (mac_cfg[2] ? mac_acc : 32'd0) +
                   prod(mac_cfg[1:0], mac_a, mac_b, mac_dual, mac_q1, mac_q2);
    end
  end
  assign mac_c = mac_acc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic ac, input logic [31:0] ini,
                              input logic [7:0] ln, input logic [31:0] av, input logic [31:0] bv,
                              input logic [7:0] d, input logic [7:0] q1, input logic [7:0] q2,
                              input logic [31:0] ex);
    vec_t v;
    v.mode = m; v.acc = ac; v.init = ini; v.len = ln; v.a_v = av; v.b_v = bv;
    v.d = d; v.q1 = q1; v.q2 = q2; v.exp_data = ex;
    return v;
  endfunction

  task automatic set_beat(input vec_t v, input int i);
    op_a    = v.a_v[8*i +: 8];
    op_b    = v.b_v[8*i +: 8];
    op_dual = v.d;
    op_q1   = v.q1;
    op_q2   = v.q2;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic ac, input logic [31:0] ini,
                          input logic [7:0] ln);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 16) begin
      tick;
      guard++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_mode = m; cmd_acc = ac; cmd_init = ini; cmd_len = ln;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Full job with back-to-back beats; checks latency, result and handshake release.
  task automatic run_job(input vec_t v, input string nm);
    int  edges;
    int  bi;
    logic hs;
    send_cmd(v.mode, v.acc, v.init, v.len);
    check($sformatf("%s_load_clr", nm), 64'(mac_clr), 64'd1);
    check($sformatf("%s_load_cfg", nm), 64'(mac_cfg), 64'({v.init, v.acc, v.mode}));
    bi = 0;
    set_beat(v, 0);
    op_valid = (v.len != 8'd0);
    edges = 0;
    while (!res_valid && edges < 64) begin
      hs = op_valid && op_ready;
      tick;
      edges++;
      if (hs) begin
        bi++;
        if (bi < int'(v.len)) set_beat(v, bi);
        else op_valid = 1'b0;
      end
    end
    op_valid = 1'b0;
    check($sformatf("%s_latency", nm), 64'(edges), 64'(int'(v.len) + 2));
    check($sformatf("%s_data", nm), 64'(res_data), 64'(v.exp_data));
    check($sformatf("%s_beats", nm), 64'(res_beats), 64'(v.len));
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    check($sformatf("%s_release", nm), 64'({res_valid, cmd_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_acc = 1'b0; cmd_init = '0;
    cmd_len = '0; abort = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_dual = '0;
    op_q1 = '0; op_q2 = '0; res_ready = 1'b0;

    vecs[0] = mk(MAC_SINGLE, 1'b1, 32'd10, 8'd4, 32'h04030201, 32'h03030303, 8'd0, 8'd0, 8'd0, 32'd40);
    vecs[1] = mk(MAC_DUAL, 1'b1, 32'd0, 8'd2, 32'h00000202, 32'h00000505, 8'd1, 8'd0, 8'd0, 32'd2580);
    vecs[2] = mk(MAC_QUAD, 1'b1, 32'd0, 8'd1, 32'h01, 32'h01, 8'd1, 8'd1, 8'd1, 32'h01010101);
    vecs[3] = mk(MAC_SINGLE, 1'b0, 32'd5, 8'd3, 32'h00040302, 32'h00050403, 8'd0, 8'd0, 8'd0, 32'd20);
    vecs[4] = mk(MAC_SINGLE, 1'b1, 32'hFFFFFFF0, 8'd2, 32'h0504, 32'h0404, 8'd0, 8'd0, 8'd0, 32'h14);
    vecs[5] = mk(2'b11, 1'b1, 32'd7, 8'd2, 32'h0303, 32'h0303, 8'd0, 8'd0, 8'd0, 32'd0);
    vecs[6] = mk(MAC_SINGLE, 1'b1, 32'hDEAD, 8'd0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 32'hDEAD);
    vecs[7] = mk(MAC_DUAL, 1'b0, 32'd99, 8'd1, 32'hFF, 32'hFF, 8'hFF, 8'd0, 8'd0, 32'h00FEFF01);

    repeat (3) tick;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_ctrl", 64'({op_ready, res_valid, mac_en, mac_clr, busy}), 64'd0);
    check("rst_data", 64'({res_data, res_beats}), 64'd0);
    check("rst_cfg", 64'(mac_cfg), 64'd0);
    rst = 1'b1;
    tick;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Multiply-only with 2-cycle op_valid gaps between beats.
    send_cmd(MAC_SINGLE, 1'b0, 32'd0, 8'd3);
    tick;
    for (int i = 0; i < 3; i++) begin
      op_a = 8'(i + 2); op_b = 8'(i + 3); op_valid = 1'b1;
      #1;
      check($sformatf("gap_en_beat%0d", i), 64'(mac_en), 64'd1);
      tick;
      op_valid = 1'b0;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          check($sformatf("gap_en_low%0d_%0d", i, g), 64'({mac_en, op_ready}), 64'(2'b01));
          tick;
        end
      end
    end
    check("gap_drain_cfg", 64'(mac_cfg), 64'({32'd0, 1'b0, MAC_SINGLE}));
    check("gap_drain_valid", 64'(res_valid), 64'd0);
    tick;
    check("gap_data", 64'({res_valid, res_data, res_beats}), 64'({1'b1, 32'd20, 8'd3}));
    check("gap_done_cfg", 64'({mac_cfg, mac_en}), 64'd0);
    res_ready = 1'b1; tick; res_ready = 1'b0;

    // Zero-length job held in DONE while res_ready stays low.
    send_cmd(MAC_SINGLE, 1'b1, 32'hDEAD, 8'd0);
    tick;
    check("zl_drain_valid", 64'(res_valid), 64'd0);
    tick;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("zl_hold%0d", c),
            64'({res_valid, cmd_ready, res_data, res_beats}), 64'({1'b1, 1'b0, 32'hDEAD, 8'd0}));
      tick;
    end
    res_ready = 1'b1; tick; res_ready = 1'b0;
    check("zl_release", 64'({res_valid, cmd_ready}), 64'(2'b01));

    // Abort on the second RUN beat, then a clean one-beat job.
    send_cmd(MAC_SINGLE, 1'b1, 32'd0, 8'd4);
    tick;
    op_a = 8'd1; op_b = 8'd1; op_valid = 1'b1;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0; op_valid = 1'b0;
    check("abort_idle", 64'({busy, op_ready, res_valid, cmd_ready}), 64'(4'b0001));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort_no_res%0d", c), 64'(res_valid), 64'd0);
      tick;
    end
    run_job(mk(MAC_SINGLE, 1'b1, 32'd0, 8'd1, 32'd7, 32'd9, 8'd0, 8'd0, 8'd0, 32'd63), "post_abort");

    // Reset asserted mid-RUN.
    send_cmd(MAC_SINGLE, 1'b1, 32'd3, 8'd4);
    tick;
    op_a = 8'd2; op_b = 8'd2; op_valid = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    check("midrst_ctrl", 64'({cmd_ready, op_ready, res_valid, mac_en, mac_clr, busy}), 64'd0);
    check("midrst_data", 64'({res_data, res_beats}), 64'd0);
    check("midrst_cfg", 64'(mac_cfg), 64'd0);
    op_valid = 1'b0;
    tick;
    check("midrst_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    tick;
    check("midrst_release", 64'({cmd_ready, busy}), 64'(2'b10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
